instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding bus fetcher feeding a small FIFO.
// Redirects flush the buffer and drop any response still in flight.
module instr_fetch_unit #(
  parameter int XLEN  = 64,
  parameter int IW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [XLEN-1:0] iInitialPC,
  output logic            oIReadEnable,
  output logic [XLEN-1:0] oIAddress,
  input  logic            iIReady,
  input  logic            iIValid,
  input  logic [IW-1:0]   iIReadData,
  input  logic            iTaken,
  input  logic [XLEN-1:0] iBranchPC,
  input  logic [XLEN-1:0] iBranchOffset,
  output logic            oValid,
  output logic [IW-1:0]   oInstr,
  output logic [XLEN-1:0] oPC,
  input  logic            iReady,
  output logic [CW-1:0]   oCount
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_q;
  logic [XLEN-1:0] target;
  logic [IW-1:0]   instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            hs;
  logic            push;
  logic            pop;

  assign target = (iBranchPC + (iBranchOffset << 2)) & ~XLEN'(3);

  assign oIReadEnable = !iRST && (state == FETCH) &&
                        (count < CW'(DEPTH)) && !iTaken;
  assign oIAddress    = pc_q;
  assign hs           = oIReadEnable & iIReady;

  assign push = (state == WAIT) && iIValid && !iTaken;
  assign pop  = oValid && iReady && !iTaken;

  // Head comes straight from buffer storage; no path from iIReadData.
  assign oValid = (count != '0);
  assign oInstr = oValid ? instr_mem[rd_ptr] : '0;
  assign oPC    = oValid ? pc_mem[rd_ptr] : '0;
  assign oCount = count;

  always_ff @(posedge iCLK) begin
    if (push) begin
      instr_mem[wr_ptr] <= iIReadData;
      pc_mem[wr_ptr]    <= req_q;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= FETCH;
      pc_q   <= iInitialPC;
      req_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (iTaken) begin
      pc_q   <= target;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      unique case (state)
        FETCH:   state <= FETCH;
        // A response arriving with the redirect retires the request.
        WAIT,
        DROP:    state <= iIValid ? FETCH : DROP;
        default: state <= FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: if (hs) begin
          pc_q  <= pc_q + XLEN'(4);
          req_q <= pc_q;
          state <= WAIT;
        end
        WAIT:    if (iIValid) state <= FETCH;
        DROP:    if (iIValid) state <= FETCH;
        default: state <= FETCH;
      endcase
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and random checks of instr_fetch_unit against a
// transaction-level model: a PC, a queue and an outstanding flag.
module tb_instr_fetch_unit;

  localparam int XLEN  = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            iCLK = 0;
  logic            iRST;
  logic [XLEN-1:0] iInitialPC;
  logic            oIReadEnable;
  logic [XLEN-1:0] oIAddress;
  logic            iIReady;
  logic            iIValid;
  logic [IW-1:0]   iIReadData;
  logic            iTaken;
  logic [XLEN-1:0] iBranchPC;
  logic [XLEN-1:0] iBranchOffset;
  logic            oValid;
  logic [IW-1:0]   oInstr;
  logic [XLEN-1:0] oPC;
  logic            iReady;
  logic [CW-1:0]   oCount;

  instr_fetch_unit #(.XLEN(XLEN), .IW(IW), .DEPTH(DEPTH)) dut (
    .iCLK(iCLK), .iRST(iRST), .iInitialPC(iInitialPC),
    .oIReadEnable(oIReadEnable), .oIAddress(oIAddress),
    .iIReady(iIReady), .iIValid(iIValid), .iIReadData(iIReadData),
    .iTaken(iTaken), .iBranchPC(iBranchPC),
    .iBranchOffset(iBranchOffset), .oValid(oValid), .oInstr(oInstr),
    .oPC(oPC), .iReady(iReady), .oCount(oCount)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [IW-1:0]   ins;
    logic [XLEN-1:0] pc;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] m_req;
  int              m_out;
  int              m_wait;
  int              resp_lat;
  ent_t            m_q[$];

  // Per-cycle stimulus
  logic            t_taken, t_ird, t_ival, t_rdy, t_auto, t_spur;
  logic [XLEN-1:0] t_bpc, t_boff;
  logic            t_rand_lat;

  function automatic logic [IW-1:0] mem_word(input logic [XLEN-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic exp_en;
    if (t_auto)
      t_ival = (m_out != 0) ? (m_wait >= resp_lat) : t_spur;
    iTaken        = t_taken;
    iBranchPC     = t_bpc;
    iBranchOffset = t_boff;
    iIReady       = t_ird;
    iIValid       = t_ival;
    iIReadData    = t_ival ? mem_word(m_req) : IW'($urandom);
    iReady        = t_rdy;
    #1;
    exp_en = (m_out == 0) && (m_q.size() < DEPTH) && !t_taken;
    chk("rd_en", XLEN'(oIReadEnable), XLEN'(exp_en));
    chk("addr", oIAddress, m_pc);
    chk("count", XLEN'(oCount), XLEN'(m_q.size()));
    chk("valid", XLEN'(oValid), XLEN'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("head_pc", oPC, m_q[0].pc);
      chk("head_ins", XLEN'(oInstr), XLEN'(m_q[0].ins));
    end
    if (m_out != 0) m_wait++;
    if (t_taken) begin
      m_q.delete();
      m_pc = t_bpc + t_boff * 4;
      m_pc = {m_pc[XLEN-1:2], 2'b00};
      if (m_out != 0) m_out = t_ival ? 0 : 2;
    end else begin
      if (t_rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (m_out != 0 && t_ival) begin
        if (m_out == 1) m_q.push_back(ent_t'{ins: mem_word(m_req), pc: m_req});
        m_out = 0;
      end else if (exp_en && t_ird) begin
        m_req  = m_pc;
        m_pc   = m_pc + 4;
        m_out  = 1;
        m_wait = 0;
        if (t_rand_lat) resp_lat = $urandom_range(0, 3);
      end
    end
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic do_reset(input logic [XLEN-1:0] pc);
    iRST = 1; iInitialPC = pc;
    iTaken = 0; iIValid = 0; iIReady = 0; iReady = 0;
    iBranchPC = '0; iBranchOffset = '0; iIReadData = '0;
    m_pc = pc; m_out = 0; m_wait = 0; m_q.delete();
    #1;
    chk("rst_en", XLEN'(oIReadEnable), '0);
    chk("rst_addr", oIAddress, pc);
    chk("rst_cnt", XLEN'(oCount), '0);
    chk("rst_valid", XLEN'(oValid), '0);
    chk("rst_ins", XLEN'(oInstr), '0);
    chk("rst_pc", oPC, '0);
    @(posedge iCLK);
    @(negedge iCLK);
    iRST = 0;
  endtask

  task automatic idle_defaults();
    t_taken = 0; t_ird = 1; t_ival = 0; t_rdy = 0;
    t_auto = 1; t_spur = 0; t_bpc = '0; t_boff = '0;
    resp_lat = 0; t_rand_lat = 0;
  endtask

  initial begin
    idle_defaults();
    @(negedge iCLK);

    // Sequential fetch from 0x400 with one-cycle response latency
    do_reset(64'h400);
    for (int i = 0; i < 6; i++) step();
    chk("seq_head", oPC, 64'h400);
    t_rdy = 1;
    for (int i = 0; i < 4; i++) step();

    // Fill the buffer, then one pop re-enables fetch
    do_reset(64'h400);
    t_rdy = 0;
    for (int i = 0; i < 12; i++) step();
    chk("full_cnt", XLEN'(oCount), 64'd4);
    chk("full_en", XLEN'(oIReadEnable), '0);
    t_rdy = 1; step();
    t_rdy = 0; step();
    step();

    // Redirect while waiting: late response dropped
    do_reset(64'h400);
    t_auto = 0; t_ival = 0;
    step();
    t_taken = 1; t_bpc = 64'h1000; t_boff = -64'sd2;
    step();
    t_taken = 0; t_ival = 1;
    step();
    t_ival = 0; t_ird = 0;
    step();
    chk("redir_addr", oIAddress, 64'hFF8);
    chk("redir_cnt", XLEN'(oCount), '0);

    // Redirect together with the response: no push, immediate fetch
    t_ird = 1;
    step();
    t_taken = 1; t_ival = 1; t_bpc = 64'h2000; t_boff = 64'd4;
    step();
    t_taken = 0; t_ival = 0;
    step();
    step();

    // Wrap from top of address space
    idle_defaults();
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    step(); step();
    chk("wrap_addr", oIAddress, '0);
    step(); step();

    // Reset mid-request, then spurious response in FETCH
    t_auto = 0; t_ival = 0;
    step();
    do_reset(64'h800);
    t_ival = 1;
    step();
    t_ival = 0;
    step();

    // Random traffic
    idle_defaults();
    t_rand_lat = 1;
    do_reset(64'h8000);
    for (int i = 0; i < 3000; i++) begin
      t_ird   = ($urandom_range(0, 3) != 0);
      t_rdy   = ($urandom_range(0, 2) != 0);
      t_spur  = ($urandom_range(0, 7) == 0);
      t_taken = ($urandom_range(0, 15) == 0);
      t_bpc   = {32'h0, $urandom} & ~64'd3;
      t_boff  = XLEN'(signed'(32'($urandom_range(0, 64)) - 32'd32));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
